// File: rtl/fc_vector_serializer.sv
// Accepts one layer output vector over valid/ready and streams it to a FIFO write port,
// LANES elements per beat, with lane-valid mask, last-beat flag and zero-bubble reload.
module fc_vector_serializer #(
   parameter int unsigned WORD_SIZE    = 8,
   parameter int unsigned LAYER_HEIGHT = 4,
   parameter int unsigned LANES        = 1,
   parameter int unsigned REVERSE      = 0
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   valid_i,
   output logic                                   ready_o,
   input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
   output logic                                   wen_o,
   input  logic                                   full_i,
   output logic [LANES-1:0][WORD_SIZE-1:0]        data_o,
   output logic [LANES-1:0]                       keep_o,
   output logic                                   last_o
);

   localparam int unsigned BEATS = (LAYER_HEIGHT + LANES - 1) / LANES;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e                                 state_q;
   logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buf_q;
   logic [CW-1:0]                          cnt_q;
   logic                                   is_last;
   logic                                   wen;
   logic                                   ready;
   logic                                   accept;

   assign is_last = (state_q == StSend) && (cnt_q == CW'(BEATS - 1));
   assign wen     = !reset_i && (state_q == StSend) && !full_i;
   // The final write frees the buffer, so a new vector may be taken on that same cycle.
   assign ready   = !reset_i && ((state_q == StIdle) || (wen && is_last));
   assign accept  = valid_i && ready;

   assign wen_o   = wen;
   assign ready_o = ready;
   assign last_o  = !reset_i && is_last;

   // Each lane picks the buffer element whose beat position matches; unmatched lanes stay zero.
   always_comb begin
      data_o = '0;
      keep_o = '0;
      if (!reset_i && (state_q == StSend)) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned e = 0; e < LAYER_HEIGHT; e++) begin
               if (32'(cnt_q) * LANES + l == ((REVERSE != 0) ? (LAYER_HEIGHT - 1 - e) : e)) begin
                  keep_o[l] = 1'b1;
                  data_o[l] = buf_q[e];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else if (accept) begin
         buf_q   <= data_i;
         cnt_q   <= '0;
         state_q <= StSend;
      end else if (wen) begin
         if (is_last) begin
            cnt_q   <= '0;
            state_q <= StIdle;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fc_vector_serializer.sv
// Directed bench for fc_vector_serializer: three configurations exercised with
// hand-computed beat sequences, back-pressure, back-to-back vectors and mid-vector reset.
module tb_fc_vector_serializer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // u0: H=4 L=1 R=0
   logic        v0 = 1'b0, f0 = 1'b0, r0, w0, k0, l0;
   logic [31:0] d0 = '0;
   logic [7:0]  q0;
   // u1: H=3 L=2 R=0
   logic        v1 = 1'b0, f1 = 1'b0, r1, w1, l1;
   logic [23:0] d1 = '0;
   logic [15:0] q1;
   logic [1:0]  k1;
   // u2: H=4 L=1 R=1
   logic        v2 = 1'b0, f2 = 1'b0, r2, w2, k2, l2;
   logic [31:0] d2 = '0;
   logic [7:0]  q2;

   int n_tests = 0;
   int n_fail  = 0;

   fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(1), .REVERSE(0)) u0 (
      .clk_i(clk), .reset_i(reset), .valid_i(v0), .ready_o(r0), .data_i(d0),
      .wen_o(w0), .full_i(f0), .data_o(q0), .keep_o(k0), .last_o(l0));

   fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(3), .LANES(2), .REVERSE(0)) u1 (
      .clk_i(clk), .reset_i(reset), .valid_i(v1), .ready_o(r1), .data_i(d1),
      .wen_o(w1), .full_i(f1), .data_o(q1), .keep_o(k1), .last_o(l1));

   fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(1), .REVERSE(1)) u2 (
      .clk_i(clk), .reset_i(reset), .valid_i(v2), .ready_o(r2), .data_i(d2),
      .wen_o(w2), .full_i(f2), .data_o(q2), .keep_o(k2), .last_o(l2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   logic [7:0] s1 [4];
   logic [7:0] s3 [4];
   logic [7:0] s5 [8];
   logic [7:0] s6 [4];

   initial begin
      s1 = '{8'h02, 8'h03, 8'h01, 8'h04};
      s3 = '{8'h04, 8'h01, 8'h03, 8'h02};
      s5 = '{8'h02, 8'h03, 8'h01, 8'h04, 8'h11, 8'h15, 8'h21, 8'h18};
      s6 = '{8'h11, 8'h15, 8'h21, 8'h18};

      // Reset behaviour
      cyc();
      settle();
      check("rst_ready", 32'(r0), 32'h0);
      check("rst_wen", 32'(w0), 32'h0);
      check("rst_out", {15'h0, l0, k0, q0}, 32'h0);
      reset = 1'b0;
      cyc();
      settle();
      check("idle_ready", 32'(r0), 32'h1);
      check("idle_wen", 32'(w0), 32'h0);
      check("idle_ready_u1", 32'(r1), 32'h1);

      // Case 1: H=4 L=1 forward
      v0 = 1'b1; d0 = 32'h04_01_03_02;
      cyc();
      v0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("c1_wen", 32'(w0), 32'h1);
         check("c1_data", 32'(q0), 32'(s1[i]));
         check("c1_keep", 32'(k0), 32'h1);
         check("c1_last", 32'(l0), (i == 3) ? 32'h1 : 32'h0);
         check("c1_ready", 32'(r0), (i == 3) ? 32'h1 : 32'h0);
         cyc();
      end
      settle();
      check("c1_done_wen", 32'(w0), 32'h0);
      check("c1_done_ready", 32'(r0), 32'h1);
      check("c1_done_last", 32'(l0), 32'h0);

      // Case 2: H=3 L=2, partial final beat
      v1 = 1'b1; d1 = 24'h0A_0B_0C;
      cyc();
      v1 = 1'b0;
      settle();
      check("c2_b0_wen", 32'(w1), 32'h1);
      check("c2_b0_data", 32'(q1), 32'h0B0C);
      check("c2_b0_keep", 32'(k1), 32'h3);
      check("c2_b0_last", 32'(l1), 32'h0);
      cyc();
      settle();
      check("c2_b1_wen", 32'(w1), 32'h1);
      check("c2_b1_data", 32'(q1), 32'h000A);
      check("c2_b1_keep", 32'(k1), 32'h1);
      check("c2_b1_last", 32'(l1), 32'h1);
      cyc();
      settle();
      check("c2_done_wen", 32'(w1), 32'h0);

      // Case 3: H=4 L=1 reversed
      v2 = 1'b1; d2 = 32'h04_01_03_02;
      cyc();
      v2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("c3_wen", 32'(w2), 32'h1);
         check("c3_data", 32'(q2), 32'(s3[i]));
         check("c3_last", 32'(l2), (i == 3) ? 32'h1 : 32'h0);
         cyc();
      end
      settle();
      check("c3_done_wen", 32'(w2), 32'h0);

      // Case 4: back-pressure for 3 cycles after the first beat
      v0 = 1'b1; d0 = 32'h04_01_03_02;
      cyc();
      v0 = 1'b0;
      settle();
      check("c4_b0_data", 32'(q0), 32'h02);
      check("c4_b0_wen", 32'(w0), 32'h1);
      cyc();
      f0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("c4_stall_wen", 32'(w0), 32'h0);
         check("c4_stall_data", 32'(q0), 32'h03);
         check("c4_stall_ready", 32'(r0), 32'h0);
         cyc();
      end
      f0 = 1'b0;
      for (int i = 1; i < 4; i++) begin
         settle();
         check("c4_wen", 32'(w0), 32'h1);
         check("c4_data", 32'(q0), 32'(s1[i]));
         check("c4_last", 32'(l0), (i == 3) ? 32'h1 : 32'h0);
         cyc();
      end
      settle();
      check("c4_done_wen", 32'(w0), 32'h0);

      // Case 5: back-to-back vectors with valid held high
      v0 = 1'b1; d0 = 32'h04_01_03_02;
      cyc();
      d0 = 32'h18_21_15_11;
      for (int i = 0; i < 8; i++) begin
         settle();
         check("c5_wen", 32'(w0), 32'h1);
         check("c5_data", 32'(q0), 32'(s5[i]));
         check("c5_ready", 32'(r0), (i == 3 || i == 7) ? 32'h1 : 32'h0);
         cyc();
         if (i == 3) v0 = 1'b0;
      end
      settle();
      check("c5_done_wen", 32'(w0), 32'h0);
      check("c5_done_ready", 32'(r0), 32'h1);

      // Case 6: reset after two beats aborts the vector
      v0 = 1'b1; d0 = 32'h04_01_03_02;
      cyc();
      v0 = 1'b0;
      settle();
      check("c6_b0_data", 32'(q0), 32'h02);
      cyc();
      settle();
      check("c6_b1_data", 32'(q0), 32'h03);
      cyc();
      reset = 1'b1;
      settle();
      check("c6_rst_wen", 32'(w0), 32'h0);
      check("c6_rst_ready", 32'(r0), 32'h0);
      check("c6_rst_out", {15'h0, l0, k0, q0}, 32'h0);
      cyc();
      reset = 1'b0;
      settle();
      check("c6_post_ready", 32'(r0), 32'h1);
      check("c6_post_wen", 32'(w0), 32'h0);
      check("c6_post_out", {15'h0, l0, k0, q0}, 32'h0);
      v0 = 1'b1; d0 = 32'h18_21_15_11;
      cyc();
      v0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("c6_wen", 32'(w0), 32'h1);
         check("c6_data", 32'(q0), 32'(s6[i]));
         check("c6_last", 32'(l0), (i == 3) ? 32'h1 : 32'h0);
         cyc();
      end
      settle();
      check("c6_done_wen", 32'(w0), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
